// File: rtl/multi_step_counter_pkg.sv
// Shared definitions for the multi-channel step counter.
//   MODE_WRAP / MODE_SAT : values of a channel's sat input
//   DEFAULT_CNT_WIDTH    : default width of each channel's count and terminal value
package multi_step_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int unsigned DEFAULT_CNT_WIDTH = 12;

endpackage

// File: rtl/step_counter_ch.sv
// One channel of the multi-channel step counter: count register, one-cycle
// overflow pulse and sticky overflow flag.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   cnt          increment request
//   clr          synchronous clear of count and sticky flag (wins over cnt)
//   sat          mode: MODE_WRAP or MODE_SAT
//   max          terminal value
//   count        registered count
//   ov           registered one-cycle overflow pulse
//   ov_sticky    registered sticky overflow flag
//   ov_nxt       next-state value of ov, used by the top to register ov_any
module step_counter_ch
    import multi_step_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt,
    input  logic                 clr,
    input  logic                 sat,
    input  logic [CNT_WIDTH-1:0] max,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ov,
    output logic                 ov_sticky,
    output logic                 ov_nxt
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ov_q, ov_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] count_inc;

    // Only used when count_q < max, so it cannot wrap.
    assign count_inc = count_q + 1'b1;

    always_comb begin
        count_d  = count_q;
        ov_d     = 1'b0;
        sticky_d = sticky_q;
        if (clr) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (cnt) begin
            if (sat == MODE_WRAP) begin
                // >= lets a lowered max recover on the next increment.
                if (count_q >= max) begin
                    count_d = '0;
                    ov_d    = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end else begin
                if (count_q < max) begin
                    count_d = count_inc;
                    ov_d    = (count_inc == max);
                end else if (count_q > max) begin
                    // max was lowered below the count: clamp and flag.
                    count_d = max;
                    ov_d    = 1'b1;
                end
            end
        end
        if (ov_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            ov_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            ov_q     <= ov_d;
            sticky_q <= sticky_d;
        end
    end

    assign count     = count_q;
    assign ov        = ov_q;
    assign ov_sticky = sticky_q;
    assign ov_nxt    = ov_d;

endmodule

// File: rtl/multi_step_counter.sv
// NUM_CH independent step counters with per-channel terminal value, wrap or
// saturate mode, synchronous clear, overflow pulse and sticky overflow flag.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   cnt        per-channel increment request
//   clr        per-channel synchronous clear
//   sat        per-channel mode (0 wrap, 1 saturate)
//   max        per-channel terminal value, channel c at [c*CNT_WIDTH +: CNT_WIDTH]
//   count      per-channel registered count, same packing as max
//   ov         per-channel one-cycle overflow pulse
//   ov_sticky  per-channel sticky overflow flag
//   ov_any     registered OR of all ov bits, aligned with ov
module multi_step_counter
    import multi_step_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH,
    parameter int unsigned NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           cnt,
    input  logic [NUM_CH-1:0]           clr,
    input  logic [NUM_CH-1:0]           sat,
    input  logic [NUM_CH*CNT_WIDTH-1:0] max,
    output logic [NUM_CH*CNT_WIDTH-1:0] count,
    output logic [NUM_CH-1:0]           ov,
    output logic [NUM_CH-1:0]           ov_sticky,
    output logic                        ov_any
);

    logic [NUM_CH-1:0] ov_nxt;
    logic              ov_any_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        step_counter_ch #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cnt       (cnt[c]),
            .clr       (clr[c]),
            .sat       (sat[c]),
            .max       (max[c*CNT_WIDTH +: CNT_WIDTH]),
            .count     (count[c*CNT_WIDTH +: CNT_WIDTH]),
            .ov        (ov[c]),
            .ov_sticky (ov_sticky[c]),
            .ov_nxt    (ov_nxt[c])
        );
    end

    // OR of next-state ov so ov_any lands in the same cycle as ov.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_any_q <= 1'b0;
        end else begin
            ov_any_q <= |ov_nxt;
        end
    end

    assign ov_any = ov_any_q;

endmodule

// File: doc/multi_step_counter.md
# multi_step_counter

Parametrised multi-channel successor to the single-channel step counter. Provides NUM_CH independent event counters of CNT_WIDTH bits. Each channel has a programmable terminal value, wrap or saturate mode, synchronous clear, a one-cycle overflow pulse and a sticky overflow flag. Sits beside the accelerator datapath and is used for tile/row stepping and for AXI-side progress monitoring.

## Interface
- CNT_WIDTH, 12: width of each channel's count and terminal value.
- NUM_CH, 4: number of independent channels (≥1).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cnt  in  NUM_CH  per-channel increment request, sampled each cycle.
- clr  in  NUM_CH  per-channel synchronous clear of count and sticky flag.
- sat  in  NUM_CH  per-channel mode: 0 = wrap, 1 = saturate.
- max  in  NUM_CH*CNT_WIDTH  per-channel terminal value; channel c occupies bits [c*CNT_WIDTH +: CNT_WIDTH]. May change any cycle.
- count  out  NUM_CH*CNT_WIDTH  registered per-channel count, same packing as max.
- ov  out  NUM_CH  registered one-cycle overflow pulse per channel.
- ov_sticky  out  NUM_CH  registered sticky overflow flag per channel.
- ov_any  out  1  registered OR of all ov bits, aligned with ov.

## Operation
- Reset: count = 0, ov = 0, ov_sticky = 0, ov_any = 0 on all channels, asynchronously.
- Per-channel priority each cycle: clr > cnt > hold.
- clr=1: count ← 0, ov_sticky ← 0, ov ← 0. Any simultaneous cnt is discarded.
- Wrap mode (sat=0), cnt=1:
  - count ≥ max: count ← 0, ov ← 1. Uses ≥ so a max lowered below the current count recovers on the next increment.
  - Otherwise: count ← count+1, ov ← 0.
- Saturate mode (sat=1), cnt=1:
  - count < max: count ← count+1, ov ← 1 iff count+1 == max.
  - count == max: hold, ov ← 0.
  - count > max: count ← max (clamp), ov ← 1.
- cnt=0 and clr=0: count holds, ov ← 0.
- ov_sticky ← 1 whenever ov is set. It is cleared only by clr or rst.
- max=0:
  - Wrap mode: every increment is terminal, count stays 0, ov pulses on every cnt cycle.
  - Saturate mode: count stays 0, no ov (unless clamping from a nonzero count).
- Arithmetic is unsigned CNT_WIDTH. count+1 never overflows the register because terminal detection precedes increment. max = 2^CNT_WIDTH−1 is legal.
- Channels are fully independent. Toggling sat mid-count takes effect at the next increment without disturbing count.

## Timing
- One-cycle latency: cnt, clr, sat and max sampled at edge N are reflected in count, ov and ov_sticky after edge N.
- ov is high exactly one cycle per terminal event. Back-to-back terminal events (e.g. max=0, wrap mode, cnt held) produce continuous ov high.
- ov_any is registered in the same cycle as ov (OR computed on next-state values), not delayed.
- Reset asserted mid-count clears all outputs immediately. After deassertion, counting resumes on the first edge with cnt=1.
- No combinational path from any input to any output.

## Structure
- Shared package/include: mode constants MODE_WRAP=0 and MODE_SAT=1, and default CNT_WIDTH.
- One sub-module, step_counter_ch:
  - Holds a single channel's count/ov/ov_sticky logic, parametrised by CNT_WIDTH.
  - Instantiated NUM_CH times in a generate loop.
- Top level handles slicing of the packed buses and the registered ov_any.

## Test plan
- Reset/idle: rst high for 2 cycles, then low with cnt=0 → all outputs 0. Assert rst mid-count at count=5 → count=0 immediately.
- Wrap, ch0, max=13 (0x00D), cnt held → count 0..13, then 0. ov high exactly the cycle count returns to 0, every 14 cycles. ov_sticky set from the first ov.
- Saturate, ch1, max=60 (0x03C), cnt held 70 cycles → count stops at 60. Single ov pulse on reaching 60. No further pulses.
- Dynamic max: ch0 wrap at count=40, max changed 60→13 → next cnt gives count=0 with ov. Same in sat mode → count clamps to 13 with ov.
- clr/cnt collision: ch2 at count=7, ov_sticky=1, clr=cnt=1 in the same cycle → count=0, ov_sticky=0, ov=0.
- Independence/max=0: ch3 max=0 wrap, cnt held while ch0 counts to max=3 → ch3 ov continuous, count 0. ch0 unaffected. ov_any = OR of per-channel ov every cycle.
